// File: rtl/error_stat_collector_if.sv
// Bundles the sample stream, FIFO readout and statistics of one error_stat_collector.
interface error_stat_collector_if #(
  parameter int DATA_W = 20,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
);
  logic                     start;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     in_ready;
  logic                     rd_en;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_empty;
  logic                     out_full;
  logic [ACC_W-1:0]         sum_abs;
  logic [DATA_W-1:0]        max_abs;
  logic [CNT_W-1:0]         sample_cnt;
  logic                     sum_sat;
  logic                     ready;

  modport master (
    output start, in_valid, in_data, in_last, rd_en,
    input  in_ready, out_data, out_empty, out_full,
    input  sum_abs, max_abs, sample_cnt, sum_sat, ready
  );

  modport slave (
    input  start, in_valid, in_data, in_last, rd_en,
    output in_ready, out_data, out_empty, out_full,
    output sum_abs, max_abs, sample_cnt, sum_sat, ready
  );
endinterface

// File: rtl/error_stat_collector.sv
// Captures regressor error samples into a FWFT FIFO and keeps per-run |error| statistics.
module error_stat_collector #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 16,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  error_stat_collector_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                   state_q;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]           cnt_q;
  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic [ACC_W-1:0]         sum_q;
  logic [DATA_W-1:0]        max_q;
  logic [CNT_W-1:0]         smp_q;
  logic                     sat_q, ready_q;

  logic                     full, empty, accept, pop, start_run;
  logic [DATA_W-1:0]        abs_d;
  logic [ACC_W:0]           sum_d;

  // Magnitude in DATA_W unsigned bits, so the most negative input maps cleanly to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] ux;
    ux = x;
    return ux[DATA_W-1] ? (~ux + DATA_W'(1)) : ux;
  endfunction

  // Top bit of the result flags overflow; the low ACC_W bits are the clamped sum.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [DATA_W-1:0] mag);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + (ACC_W+1)'(mag);
    return s[ACC_W] ? {1'b1, {ACC_W{1'b1}}} : s;
  endfunction

  assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign start_run = bus.start && (state_q != COLLECT);
  assign accept    = bus.in_valid && bus.in_ready;
  assign pop       = bus.rd_en && !empty;
  assign abs_d     = abs_mag(bus.in_data);
  assign sum_d     = sat_add(sum_q, abs_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      max_q    <= '0;
      smp_q    <= '0;
      sat_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else if (start_run) begin
      state_q  <= COLLECT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      max_q    <= '0;
      smp_q    <= '0;
      sat_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        sum_q    <= sum_d[ACC_W-1:0];
        sat_q    <= sat_q | sum_d[ACC_W];
        if (abs_d > max_q) max_q <= abs_d;
        if (smp_q != '1)   smp_q <= smp_q + CNT_W'(1);
        if (bus.in_last) begin
          state_q <= DONE;
          ready_q <= 1'b1;
        end
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (accept && !pop)      cnt_q <= cnt_q + (PTR_W+1)'(1);
      else if (!accept && pop) cnt_q <= cnt_q - (PTR_W+1)'(1);
    end
  end

  // Storage is data only; validity is carried entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= bus.in_data;
  end

  assign bus.in_ready   = (state_q == COLLECT) && !full;
  assign bus.out_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.out_empty  = empty;
  assign bus.out_full   = full;
  assign bus.sum_abs    = sum_q;
  assign bus.max_abs    = max_q;
  assign bus.sample_cnt = smp_q;
  assign bus.sum_sat    = sat_q;
  assign bus.ready      = ready_q;
endmodule

// File: tb/tb_error_stat_collector.sv
// Randomised and directed scoreboard bench for error_stat_collector with a queue-based run model.
module tb_error_stat_collector;
  localparam int DATA_W = 20;
  localparam int DEPTH  = 16;
  localparam int ACC_W  = 20;
  localparam int CNT_W  = 16;
  localparam longint MAXSUM = (longint'(1) << ACC_W) - 1;
  localparam longint MAXCNT = (longint'(1) << CNT_W) - 1;

  typedef struct {
    longint sum;
    longint mx;
    longint cnt;
    longint sat;
  } stat_t;

  logic clk = 1'b0;
  logic rst;

  error_stat_collector_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  error_stat_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DATA_W-1:0] exp_data_q[$];
  stat_t                    exp_stat_q[$];
  bit     m_collect = 1'b0;
  bit     m_ready   = 1'b0;
  longint m_sum = 0, m_max = 0, m_cnt = 0, m_sat = 0;
  bit     mon_en    = 1'b0;
  bit     prev_ready = 1'b0;
  bit     drv_done;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic model_clear_run();
    exp_data_q.delete();
    m_sum = 0; m_max = 0; m_cnt = 0; m_sat = 0;
    m_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear_run();
    exp_stat_q.delete();
    m_collect = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (!m_collect) begin
      model_clear_run();
      m_collect = 1'b1;
    end
  endtask

  task automatic send(input logic signed [DATA_W-1:0] d, input bit last);
    bit     got;
    longint dv, a;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      bus.in_valid = 1'b0;
      fail_now("send_timeout");
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    exp_data_q.push_back(d);
    dv = longint'(d);
    a  = (dv < 0) ? -dv : dv;
    if (m_sum + a > MAXSUM) begin
      m_sum = MAXSUM;
      m_sat = 1;
    end else begin
      m_sum = m_sum + a;
    end
    if (a > m_max) m_max = a;
    if (m_cnt < MAXCNT) m_cnt = m_cnt + 1;
    if (last) begin
      m_collect = 1'b0;
      m_ready   = 1'b1;
      exp_stat_q.push_back('{m_sum, m_max, m_cnt, m_sat});
    end
  endtask

  task automatic drain();
    bus.rd_en = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      @(negedge clk);
      if (bus.out_empty) break;
      @(posedge clk); #1;
    end
    bus.rd_en = 1'b0;
    #1;
    check("drain_empty", longint'(bus.out_empty), 1);
  endtask

  task automatic check_stats(input string tag, input longint s, input longint mx,
                             input longint c, input longint sat);
    check({tag, "_sum_abs"},    longint'(bus.sum_abs),    s);
    check({tag, "_max_abs"},    longint'(bus.max_abs),    mx);
    check({tag, "_sample_cnt"}, longint'(bus.sample_cnt), c);
    check({tag, "_sum_sat"},    longint'(bus.sum_sat),    sat);
  endtask

  // Monitor: control flags every cycle, FIFO reads and completed-run stats from the queues.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("in_ready",  longint'(bus.in_ready),  longint'(m_collect && (exp_data_q.size() < DEPTH)));
      check("out_empty", longint'(bus.out_empty), longint'(exp_data_q.size() == 0));
      check("out_full",  longint'(bus.out_full),  longint'(exp_data_q.size() == DEPTH));
      check("ready",     longint'(bus.ready),     longint'(m_ready));
      if (bus.out_empty) check("out_data_when_empty", longint'(bus.out_data), 0);
      if (bus.rd_en && !bus.out_empty) begin
        if (exp_data_q.size() == 0) fail_now("rd_data_unexpected");
        else check("rd_data", longint'(bus.out_data), longint'(exp_data_q.pop_front()));
      end
      if (bus.ready && !prev_ready) begin
        if (exp_stat_q.size() == 0) begin
          fail_now("stats_unexpected_ready");
        end else begin
          stat_t e;
          e = exp_stat_q.pop_front();
          check("run_sum_abs",    longint'(bus.sum_abs),    e.sum);
          check("run_max_abs",    longint'(bus.max_abs),    e.mx);
          check("run_sample_cnt", longint'(bus.sample_cnt), e.cnt);
          check("run_sum_sat",    longint'(bus.sum_sat),    e.sat);
        end
      end
    end
    prev_ready = bus.ready;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [DATA_W-1:0] v;
    int n, mode;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.rd_en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    check("rst_out_empty", longint'(bus.out_empty), 1);
    check("rst_out_full",  longint'(bus.out_full),  0);
    check("rst_in_ready",  longint'(bus.in_ready),  0);
    check("rst_out_data",  longint'(bus.out_data),  0);
    check("rst_ready",     longint'(bus.ready),     0);
    check_stats("rst", 0, 0, 0, 0);

    // Basic run; a start pulse mid-run must be ignored.
    do_start();
    send(5, 1'b0);
    send(-3, 1'b0);
    do_start();
    send(-12, 1'b0);
    send(7, 1'b1);
    check_stats("basic", 27, 12, 4, 0);
    check("basic_ready", longint'(bus.ready), 1);
    drain();

    // Most negative sample.
    do_start();
    send(DATA_W'(-524288), 1'b1);
    check_stats("minneg", 524288, 524288, 1, 0);
    drain();

    // Fill to full, hold off a 17th sample until one read frees a slot.
    do_start();
    for (int i = 0; i < DEPTH; i++) send(DATA_W'(i * 3 - 20), 1'b0);
    check("full_out_full", longint'(bus.out_full), 1);
    check("full_in_ready", longint'(bus.in_ready), 0);
    fork
      send(DATA_W'(1000), 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("held_in_ready", longint'(bus.in_ready), 0);
        bus.rd_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_en = 1'b0;
      end
    join
    drain();

    // Sum saturation.
    do_start();
    send(DATA_W'(524287), 1'b0);
    send(DATA_W'(524287), 1'b0);
    send(DATA_W'(524287), 1'b1);
    check_stats("sat", 1048575, 524287, 3, 1);
    drain();

    // Reset mid-run discards everything.
    do_start();
    send(10, 1'b0);
    send(-20, 1'b0);
    send(30, 1'b0);
    do_reset();
    check("midrst_out_empty", longint'(bus.out_empty), 1);
    check_stats("midrst", 0, 0, 0, 0);
    do_start();
    send(1, 1'b0);
    send(2, 1'b1);
    check_stats("after_rst", 3, 2, 2, 0);

    // Start from DONE clears stats and FIFO; reading empty is harmless.
    do_start();
    check_stats("restart", 0, 0, 0, 0);
    check("restart_ready",     longint'(bus.ready),     0);
    check("restart_in_ready",  longint'(bus.in_ready),  1);
    check("restart_out_empty", longint'(bus.out_empty), 1);
    bus.rd_en = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    check("empty_rd_out_empty", longint'(bus.out_empty), 1);
    check("empty_rd_out_data",  longint'(bus.out_data),  0);
    send(-4, 1'b1);
    drain();

    // Random runs with gaps and concurrent random reads.
    for (int run = 0; run < 12; run++) begin
      do_start();
      n    = $urandom_range(1, 24);
      mode = $urandom_range(0, 2);
      drv_done = 1'b0;
      fork
        begin
          for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            case (mode)
              0:       v = DATA_W'(int'($urandom_range(0, 200)) - 100);
              1:       v = DATA_W'($urandom);
              default: begin
                case ($urandom_range(0, 3))
                  0:       v = DATA_W'(-524288);
                  1:       v = DATA_W'(524287);
                  2:       v = DATA_W'(-1);
                  default: v = '0;
                endcase
              end
            endcase
            send(v, k == n - 1);
          end
          drv_done = 1'b1;
        end
        begin
          while (!drv_done) begin
            bus.rd_en = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
          end
          bus.rd_en = 1'b0;
        end
      join
      drain();
    end

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/error_stat_collector.md
Name: error_stat_collector

Overview:
Downstream consumer of the linear regressor's per-sample error output (Vect_E). It captures each signed error sample into a small first-word-fall-through FIFO for later readout and computes run statistics on the fly: sum of absolute errors, maximum absolute error and sample count. A start/ready-style control FSM delimits one regression run.

Parameters:
DATA_W, 20, width of a signed two's-complement error sample (matches Vect_E)
DEPTH, 16, FIFO depth in samples, power of two, >= 2
ACC_W, 32, width of the sum-of-absolute-errors accumulator
CNT_W, 16, width of the sample counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  begin a new collection run; sampled on a clk edge
in_valid  input  1  in_data is valid this cycle
in_data  input  DATA_W  signed error sample
in_last  input  1  marks the final sample of the run; qualified by in_valid
in_ready  output  1  block can accept a sample this cycle
rd_en  input  1  pop FIFO head
out_data  output  DATA_W  FIFO head (FWFT); 0 when empty
out_empty  output  1  FIFO empty
out_full  output  1  FIFO full
sum_abs  output  ACC_W  saturating sum of |error|
max_abs  output  DATA_W  unsigned maximum |error|
sample_cnt  output  CNT_W  accepted samples this run, saturating
sum_sat  output  1  sum_abs has saturated (sticky per run)
ready  output  1  run complete; statistics are final

Behaviour:
- Reset (rst=1 at a clk edge): FSM -> IDLE. FIFO pointers and count cleared. out_data=0, out_empty=1, out_full=0, in_ready=0, sum_abs=0, max_abs=0, sample_cnt=0, sum_sat=0, ready=0. Reset mid-run discards all data; no partial stats remain.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: start -> COLLECT.
  - COLLECT: accept samples; an accepted sample with in_last=1 -> DONE.
  - DONE: start -> COLLECT.
- Entering COLLECT (the start edge) clears sum_abs, max_abs, sample_cnt, sum_sat, ready and the FIFO in the same edge.
- start while in COLLECT is ignored.
- in_ready = (state==COLLECT) && !out_full. This is combinational from registered state.
- Accept = in_valid && in_ready. Samples presented while in_ready=0 are dropped; the upstream must hold them.
- On accept, at the same edge:
  - push in_data into the FIFO;
  - sample_cnt += 1, saturating at 2^CNT_W-1;
  - abs = in_data<0 ? -in_data : in_data, computed in DATA_W-bit unsigned; -2^(DATA_W-1) maps to 2^(DATA_W-1) with no overflow;
  - max_abs = max(max_abs, abs);
  - sum_abs += abs, zero-extended. If the true sum exceeds 2^ACC_W-1, sum_abs holds 2^ACC_W-1 and sum_sat=1.
  - Statistics are visible one cycle after the accepting edge.
- ready=1 from the edge that accepts the in_last sample (together with that sample's stat update) until the next start or rst. in_ready=0 in DONE.
- FIFO behaviour:
  - FWFT: out_data equals the head entry whenever out_empty=0.
  - rd_en && !out_empty pops at the edge; rd_en while empty is ignored, with no pointer change.
  - Pointers wrap modulo DEPTH; full/empty are derived from an occupancy count of log2(DEPTH)+1 bits.
  - Push and pop in the same cycle (not empty, not full): occupancy unchanged, both pointers advance.
  - Push when full cannot occur because in_ready=0. A pop in the same cycle does not re-enable in_ready until the next cycle.
  - Reads are allowed in any state, including IDLE and DONE.
- start and accept on the same edge while in DONE: start wins. The sample is not accepted because in_ready=0 in DONE.
- Latency: sample in -> visible at out_data = 1 cycle when the FIFO was empty.

Test Plan:
- Reset, then start, then samples +5, -3, -12, +7 (last on +7) with no stalls -> sum_abs=27, max_abs=12, sample_cnt=4, ready=1 on the edge after +7. Reads return 5, -3, -12, 7 in order, then out_empty=1.
- Single sample -524288 (0x80000) with in_last -> max_abs=0x80000, sum_abs=524288, sum_sat=0.
- DEPTH=16: push 16 samples with no reads -> out_full=1, in_ready=0. A 17th in_valid is held off. One rd_en -> in_ready=1 the next cycle and the 17th sample is accepted. The wrap order is preserved.
- ACC_W=20: feed 3 samples of +0x7FFFF -> sum_abs=0xFFFFF, sum_sat=1, sample_cnt=3.
- Assert rst after 3 of 6 samples, then start and feed 2 samples {1, 2} with last -> sum_abs=3, sample_cnt=2. No stale FIFO data.
- In DONE, assert start -> stats and FIFO cleared, ready=0, in_ready=1 the next cycle. rd_en on an empty FIFO leaves out_empty=1 and out_data=0.
